fetch_stage: RTL

//  Instruction-fetch (F) stage of the 5-stage MIPS pipeline. Holds the PC and reads the

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_npc_calc.sv | 42 ++++
 rtl/fetch_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and the D-stage decoder.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   npc_op_e      next-PC selector encoding, shared with the D-stage decoder
//   DEF_*         default reset PC, ROM base address and ROM depth
//   sext16_sl2()  sign-extended 16-bit branch offset, scaled to bytes
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JREG   = 2'b11
  } npc_op_e;

  localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam int          DEF_IM_WORDS = 4096;

  // Branch offsets count words; turn one into a signed byte displacement.
  function automatic logic [31:0] sext16_sl2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Next-PC selection for the fetch stage: sequential, branch, jump or jump-register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is loaded.
//
// Ports:
//   pc        in  32  PC currently in F
//   pc_d      in  32  PC of the instruction in D (the one issuing the redirect)
//   imm26_d   in  26  instr[25:0] of the D instruction; imm16 is the low half
//   rs_val_d  in  32  forwarded rs value (jr/jalr target)
//   npc_op    in  2   redirect type from D
//   br_cond   in  1   branch comparison result, meaningful only for NPC_BRANCH
//   npc       out 32  PC to load on the next non-frozen edge
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_d,
  input  logic [25:0] imm26_d,
  input  logic [31:0] rs_val_d,
  input  npc_op_e     npc_op,
  input  logic        br_cond,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  // Branch and jump targets are relative to the D instruction, not to pc: pc
  // already holds the delay-slot address pc_d+4 when D resolves the redirect.
  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      NPC_SEQ:    npc = pc_plus4;
      NPC_BRANCH: if (br_cond) npc = pc_d + 32'd4 + sext16_sl2(imm26_d[15:0]);
      NPC_JUMP:   npc = {pc_d[31:28], imm26_d, 2'b00};
      NPC_JREG:   npc = rs_val_d;
      default:    npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction ROM lookup, fault check, fetch counter.
// Latency: OP_F_o/PCn_F_o/fetch_fault are combinational from pc (zero-cycle ROM read).
// Backpressure: freeze holds pc and fetch_cnt; the redirect from D is ignored while frozen.
//
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   asynchronous active-high reset
//   freeze       in  1   hazard-unit stall
//   npc_op       in  2   redirect type from D (fetch_stage_pkg::npc_op_e encoding)
//   br_cond      in  1   branch comparison result from D
//   imm26_d      in  26  instr[25:0] of the D instruction
//   pc_d         in  32  PC of the D instruction
//   rs_val_d     in  32  forwarded rs value, jr target
//   OP_F_o       out 32  fetched instruction word (0 when faulted)
//   PCn_F_o      out 32  PC of OP_F_o
//   fetch_fault  out 1   pc misaligned or outside the ROM window
//   fetch_cnt    out 32  non-frozen fetch edges since reset (wraps)
//
// The ROM image is supplied as the flat parameter IM_IMAGE (word i at bits
// [32*i +: 32]) so contents are fixed at elaboration without any load logic.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0]            PC_RESET = DEF_PC_RESET,
  parameter logic [31:0]            IM_BASE  = DEF_IM_BASE,
  parameter int                     IM_WORDS = DEF_IM_WORDS,
  parameter logic [IM_WORDS*32-1:0] IM_IMAGE = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic [1:0]  npc_op,
  input  logic        br_cond,
  input  logic [25:0] imm26_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] rs_val_d,
  output logic [31:0] OP_F_o,
  output logic [31:0] PCn_F_o,
  output logic        fetch_fault,
  output logic [31:0] fetch_cnt
);

  localparam int AW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;
  // One past the last ROM byte; 33 bits so a window ending at 2^32 still compares correctly.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

  logic [31:0]   pc;
  logic [31:0]   npc;
  logic [AW-1:0] rom_idx;
  logic [31:0]   rom_word;

  npc_calc u_npc_calc (
    .pc       (pc),
    .pc_d     (pc_d),
    .imm26_d  (imm26_d),
    .rs_val_d (rs_val_d),
    .npc_op   (npc_op_e'(npc_op)),
    .br_cond  (br_cond),
    .npc      (npc)
  );

  // Freeze has priority over any redirect: D re-presents it after the stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= PC_RESET;
      fetch_cnt <= '0;
    end else if (!freeze) begin
      pc        <= npc;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign fetch_fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_END);

  // The index is only meaningful when not faulted; the output mux below hides
  // whatever an out-of-window pc happens to select.
  assign rom_idx  = AW'((pc - IM_BASE) >> 2);
  assign rom_word = IM_IMAGE[{rom_idx, 5'b00000} +: 32];

  assign OP_F_o  = fetch_fault ? 32'h0 : rom_word;
  assign PCn_F_o = pc;

endmodule
